vga_sync: RTL and testbench

// - Raster timing generator: the producer of the pixel coordinates that all

---
 rtl/vga_sync_if.sv | 29 ++
 rtl/vga_sync.sv | 111 +++++++++++
 tb/tb_vga_sync.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Raster timing bundle carried from vga_sync to the region detectors.
// Optional member frame_tick exists only when VGA_FRAME_TICK_EN is defined.
interface vga_sync_if;
  logic       pixel_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
`ifdef VGA_FRAME_TICK_EN
  logic       frame_tick;
`endif

  // The timing generator drives everything.
  modport master (
    output pixel_tick, x, y, video_on, hsync, vsync
`ifdef VGA_FRAME_TICK_EN
    , output frame_tick
`endif
  );

  // Consumers only observe.
  modport slave (
    input pixel_tick, x, y, video_on, hsync, vsync
`ifdef VGA_FRAME_TICK_EN
    , input frame_tick
`endif
  );
endinterface

// File: rtl/vga_sync.sv
// vga_sync: raster timing generator. Divides clk down to a pixel tick, runs
// the x/y counters and drives registered video_on/hsync/vsync decodes.
// Optional feature: define VGA_FRAME_TICK_EN to add a once-per-frame
// frame_tick pulse at the start of vertical blanking.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  vga_sync_if.master  vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_LAST = 10'(H_DISPLAY - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Totals must fit the 10-bit coordinate outputs.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_check
    $error("vga_sync: H_TOTAL/V_TOTAL must fit in 10 bits and CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick_now;
  logic [9:0]       x_q, y_q, x_nxt, y_nxt;
  logic             tick_q, von_q, hs_q, vs_q;

  // Next raster position: only moves on the clk where the divider wraps.
  always_comb begin
    tick_now = (div_cnt == DIV_LAST);
    x_nxt    = x_q;
    y_nxt    = y_q;
    if (tick_now) begin
      if (x_q < H_LAST) begin
        x_nxt = x_q + 10'd1;
      end else begin
        x_nxt = '0;
        if (y_q < V_LAST) begin
          y_nxt = y_q + 10'd1;
        end else begin
          y_nxt = '0;
        end
      end
    end
  end

  // Divider, counters and decodes share one edge so decode latency to x/y is zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      von_q   <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
    end else begin
      div_cnt <= tick_now ? '0 : div_cnt + DIV_ONE;
      tick_q  <= tick_now;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      von_q   <= (x_nxt <= H_VIS_LAST) && (y_nxt <= V_VIS_LAST);
      hs_q    <= ((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vs_q    <= ((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.pixel_tick = tick_q;
  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.video_on   = von_q;
  assign vga.hsync      = hs_q;
  assign vga.vsync      = vs_q;

`ifdef VGA_FRAME_TICK_EN
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
  logic ft_q;

  // Pulse on the tick that enters the first blanking line at x=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ft_q <= 1'b0;
    end else begin
      ft_q <= tick_now && (x_nxt == 10'd0) && (y_nxt == V_VIS);
    end
  end

  assign vga.frame_tick = ft_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Testbench for vga_sync. Three instances (reduced timing, divide-by-1 with
// active-high sync, and default 640x480) run off a shared clock and reset and
// are compared every cycle against an arithmetic raster model.
module tb_vga_sync;

  // Instance A: short raster, divide by 4, active-low sync.
  localparam int A_DIV = 4;
  localparam int A_HD = 20, A_HF = 4, A_HS = 6, A_HB = 5;
  localparam int A_VD = 12, A_VF = 2, A_VS = 2, A_VB = 3;
  localparam bit A_POL = 1'b0;
  // Instance B: tick every clk, active-high sync.
  localparam int B_DIV = 1;
  localparam int B_HD = 10, B_HF = 2, B_HS = 3, B_HB = 4;
  localparam int B_VD = 5, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam bit B_POL = 1'b1;
  // Instance C: default 640x480 timing.
  localparam int C_DIV = 4;
  localparam int C_HD = 640, C_HF = 16, C_HS = 96, C_HB = 48;
  localparam int C_VD = 480, C_VF = 10, C_VS = 2, C_VB = 33;
  localparam bit C_POL = 1'b0;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset_n;
  longint n = 0;
  int    total = 0;
  int    bad = 0;

  vga_sync_if bus_a();
  vga_sync_if bus_b();
  vga_sync_if bus_c();

  vga_sync #(.CLK_DIV(A_DIV), .H_DISPLAY(A_HD), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
             .V_DISPLAY(A_VD), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB), .SYNC_POL(A_POL))
    dut_a (.clk(clk), .reset_n(reset_n), .vga(bus_a));

  vga_sync #(.CLK_DIV(B_DIV), .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
             .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .SYNC_POL(B_POL))
    dut_b (.clk(clk), .reset_n(reset_n), .vga(bus_b));

  vga_sync dut_c (.clk(clk), .reset_n(reset_n), .vga(bus_c));

  // 10 ns clock.
  always #5 clk = ~clk;

  // Clock edges seen since the last reset release; the whole model is a function of this.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) n <= 0;
    else          n <= n + 1;
  end

  // Raster position from elapsed edges: k ticks so far, wrapped over the frame area.
  function automatic exp_t model(input longint edges, input int cdiv,
                                 input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb,
                                 input bit pol);
    exp_t   e;
    longint k, p;
    int     ht, vt, xi, yi;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    e  = '0;
    if (edges == 0) begin
      e.hs = ~pol;
      e.vs = ~pol;
      return e;
    end
    k  = edges / cdiv;
    p  = k % longint'(ht * vt);
    xi = int'(p % longint'(ht));
    yi = int'(p / longint'(ht));
    e.tick = ((edges % cdiv) == 0);
    e.x    = xi[9:0];
    e.y    = yi[9:0];
    e.von  = (xi < hd) && (yi < vd);
    e.hs   = (xi >= hd + hf && xi < hd + hf + hsw) ? pol : ~pol;
    e.vs   = (yi >= vd + vf && yi < vd + vf + vsw) ? pol : ~pol;
    e.ft   = e.tick && (xi == 0) && (yi == vd);
    return e;
  endfunction

  // One comparison: counted always, reported on mismatch.
  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one instance's observed outputs with its expected struct.
  task automatic checkDut(input string tag, input exp_t e, input logic tick,
                          input logic [9:0] x, input logic [9:0] y, input logic von,
                          input logic hs, input logic vs, input logic ft);
    checkOutput({tag, ".pixel_tick"}, {9'd0, tick}, {9'd0, e.tick});
    checkOutput({tag, ".x"}, x, e.x);
    checkOutput({tag, ".y"}, y, e.y);
    checkOutput({tag, ".video_on"}, {9'd0, von}, {9'd0, e.von});
    checkOutput({tag, ".hsync"}, {9'd0, hs}, {9'd0, e.hs});
    checkOutput({tag, ".vsync"}, {9'd0, vs}, {9'd0, e.vs});
`ifdef VGA_FRAME_TICK_EN
    checkOutput({tag, ".frame_tick"}, {9'd0, ft}, {9'd0, e.ft});
`else
    if (ft !== 1'b0) checkOutput({tag, ".frame_tick_absent"}, {9'd0, ft}, 10'd0);
`endif
  endtask

  // Every falling edge, all three instances against the model.
  always @(negedge clk) begin
    logic fa, fb, fc;
`ifdef VGA_FRAME_TICK_EN
    fa = bus_a.frame_tick;
    fb = bus_b.frame_tick;
    fc = bus_c.frame_tick;
`else
    fa = 1'b0;
    fb = 1'b0;
    fc = 1'b0;
`endif
    checkDut("A", model(n, A_DIV, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, A_POL),
             bus_a.pixel_tick, bus_a.x, bus_a.y, bus_a.video_on, bus_a.hsync, bus_a.vsync, fa);
    checkDut("B", model(n, B_DIV, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_POL),
             bus_b.pixel_tick, bus_b.x, bus_b.y, bus_b.video_on, bus_b.hsync, bus_b.vsync, fb);
    checkDut("C", model(n, C_DIV, C_HD, C_HF, C_HS, C_HB, C_VD, C_VF, C_VS, C_VB, C_POL),
             bus_c.pixel_tick, bus_c.x, bus_c.y, bus_c.video_on, bus_c.hsync, bus_c.vsync, fc);
  end

  // Literal reset values, checked with no clock edge needed.
  task automatic checkResetLiterals(input string tag);
    checkOutput({tag, ".A.x"}, bus_a.x, 10'd0);
    checkOutput({tag, ".A.y"}, bus_a.y, 10'd0);
    checkOutput({tag, ".A.video_on"}, {9'd0, bus_a.video_on}, 10'd0);
    checkOutput({tag, ".A.pixel_tick"}, {9'd0, bus_a.pixel_tick}, 10'd0);
    checkOutput({tag, ".A.hsync"}, {9'd0, bus_a.hsync}, 10'd1);
    checkOutput({tag, ".A.vsync"}, {9'd0, bus_a.vsync}, 10'd1);
    checkOutput({tag, ".B.hsync"}, {9'd0, bus_b.hsync}, 10'd0);
    checkOutput({tag, ".C.vsync"}, {9'd0, bus_c.vsync}, 10'd1);
  endtask

  // Run, then assert reset between edges, check asynchronous clear, hold, release.
  task automatic applyStimulus(input int run_clks, input int rst_offset, input int rst_clks);
    repeat (run_clks) @(posedge clk);
    #(rst_offset);
    reset_n = 1'b0;
    #1;
    checkResetLiterals("async_rst");
    repeat (rst_clks) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkResetLiterals("por");
    #1;
    reset_n = 1'b1;

    // First edge after release loads video_on at (0,0); first tick CLK_DIV edges later.
    @(posedge clk); #1;
    checkOutput("pin.A.video_on_first_edge", {9'd0, bus_a.video_on}, 10'd1);
    checkOutput("pin.A.tick_first_edge", {9'd0, bus_a.pixel_tick}, 10'd0);
    checkOutput("pin.B.tick_first_edge", {9'd0, bus_b.pixel_tick}, 10'd1);
    checkOutput("pin.B.x_first_edge", bus_b.x, 10'd1);
    repeat (3) @(posedge clk); #1;
    checkOutput("pin.A.first_tick", {9'd0, bus_a.pixel_tick}, 10'd1);
    checkOutput("pin.A.x_first_tick", bus_a.x, 10'd1);
    checkOutput("pin.C.x_first_tick", bus_c.x, 10'd1);

    // Default timing: hsync becomes active at x=656, 2624 edges after release.
    repeat (2620) @(posedge clk); #1;
    checkOutput("pin.C.x_656", bus_c.x, 10'd656);
    checkOutput("pin.C.hsync_656", {9'd0, bus_c.hsync}, 10'd0);
    checkOutput("pin.C.video_on_656", {9'd0, bus_c.video_on}, 10'd0);
    #1;

    // Several full frames of A, then a reset pulse.
    applyStimulus(5400, 2, 3);

    // Mid-frame, mid-divider reset at A's (17,8): 297 ticks plus 2 clks.
    repeat (1190) @(posedge clk); #1;
    checkOutput("pin.A.x_mid", bus_a.x, 10'd17);
    checkOutput("pin.A.y_mid", bus_a.y, 10'd8);
    checkOutput("pin.A.video_on_mid", {9'd0, bus_a.video_on}, 10'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkResetLiterals("mid_rst");
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    checkOutput("pin.A.restart_tick", {9'd0, bus_a.pixel_tick}, 10'd1);
    checkOutput("pin.A.restart_x", bus_a.x, 10'd1);

    // Entry to vertical blanking of A: (34,11) -> (0,12) after 420 ticks.
    repeat (1676) @(posedge clk); #1;
    checkOutput("pin.A.vblank_x", bus_a.x, 10'd0);
    checkOutput("pin.A.vblank_y", bus_a.y, 10'd12);
    checkOutput("pin.A.vblank_video_on", {9'd0, bus_a.video_on}, 10'd0);
`ifdef VGA_FRAME_TICK_EN
    checkOutput("pin.A.frame_tick", {9'd0, bus_a.frame_tick}, 10'd1);
`endif
    #1;

    // Random run lengths and reset pulses.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(int'($urandom_range(1, 2500)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 6)));
    end
    repeat (100) @(posedge clk);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
